// File: rtl/dm_mem_ctrl_pkg.sv
// rtl/dm_mem_ctrl_pkg.sv - shared constants and types for the debug-memory controller
// Purpose : debug-memory region map, command FSM state enum, region enum and a range helper.
// Ports   : none (package).
package dm_mem_ctrl_pkg;

  // Single-word mailbox registers written by the hart
  localparam logic [31:0] HaltedAddr    = 32'h100;
  localparam logic [31:0] GoingAddr     = 32'h108;
  localparam logic [31:0] ResumingAddr  = 32'h110;
  localparam logic [31:0] ExceptionAddr = 32'h118;

  // Readable regions
  localparam logic [31:0] WheretoAddr   = 32'h300;
  localparam logic [31:0] AbsCmdBase    = 32'h330;
  localparam logic [31:0] AbsCmdLimit   = 32'h33F;
  localparam logic [31:0] ProgBufBase   = 32'h340;
  localparam logic [31:0] ProgBufLimit  = 32'h37F;
  localparam logic [31:0] DataBase      = 32'h380;
  localparam logic [31:0] FlagsBase     = 32'h400;
  localparam logic [31:0] FlagsLimit    = 32'h407;

  typedef enum logic [1:0] {
    IDLE,
    GO,
    CMD_EXEC,
    RESUME
  } dm_cmd_state_e;

  typedef enum logic [3:0] {
    NONE,
    HALTED,
    GOING,
    RESUMING,
    EXCEPTION,
    WHERETO,
    ABSCMD,
    PROGBUF,
    DATA,
    FLAGS
  } dm_region_e;

  function automatic logic in_range(input logic [31:0] a, input logic [31:0] base,
                                    input logic [31:0] limit);
    return (a >= base) && (a <= limit);
  endfunction

endpackage

// File: rtl/dm_mem_addr_decode.sv
// rtl/dm_mem_addr_decode.sv - combinational debug-memory address decoder
// Purpose : map a byte address onto a debug-memory region and flag read-only regions.
// Ports   : addr_i (byte address) -> region_o (dm_region_e), read_only_o (1 = writes not allowed).
module dm_mem_addr_decode
  import dm_mem_ctrl_pkg::*;
#(
  parameter int unsigned DbgAddressBits = 12,
  parameter int unsigned DataCount      = 2
) (
  input  logic [DbgAddressBits-1:0] addr_i,
  output dm_region_e                region_o,
  output logic                      read_only_o
);

  localparam logic [31:0] DataLimit = DataBase + 32'(4 * DataCount) - 32'd1;

  logic [31:0] addr;
  assign addr = 32'(addr_i);

  always_comb begin
    region_o = NONE;
    if      (in_range(addr, HaltedAddr,    HaltedAddr    + 32'd3)) region_o = HALTED;
    else if (in_range(addr, GoingAddr,     GoingAddr     + 32'd3)) region_o = GOING;
    else if (in_range(addr, ResumingAddr,  ResumingAddr  + 32'd3)) region_o = RESUMING;
    else if (in_range(addr, ExceptionAddr, ExceptionAddr + 32'd3)) region_o = EXCEPTION;
    else if (in_range(addr, WheretoAddr,   WheretoAddr   + 32'd3)) region_o = WHERETO;
    else if (in_range(addr, AbsCmdBase,    AbsCmdLimit))           region_o = ABSCMD;
    else if (in_range(addr, ProgBufBase,   ProgBufLimit))          region_o = PROGBUF;
    else if (in_range(addr, DataBase,      DataLimit))             region_o = DATA;
    else if (in_range(addr, FlagsBase,     FlagsLimit))            region_o = FLAGS;
  end

  assign read_only_o = (region_o == WHERETO) || (region_o == ABSCMD) ||
                       (region_o == PROGBUF) || (region_o == FLAGS);

endmodule

// File: rtl/dm_mem_ctrl.sv
// rtl/dm_mem_ctrl.sv - debug-memory bus front-end and abstract-command sequencer
// Purpose : decode hart debug-memory requests into datapath enables, return a registered
//           response (rvalid/err) and run the go/resume command handshake with the DM core.
// Ports   : hart bus (req_i, we_i, addr_i, be_i, rvalid_o, err_o); DM core (cmd_valid_i,
//           resumereq_i, cmdbusy_o, cmderror_valid_o); datapath (flags_o, wr_*_en_o,
//           wr_data_addr_o, rd_*_en_o, rd_addr_o, halted_i).
// Config  : DM_CMD_TIMEOUT_EN enables the TimeoutCycles command abort counter.
module dm_mem_ctrl
  import dm_mem_ctrl_pkg::*;
#(
  parameter int unsigned DbgAddressBits = 12,
  parameter int unsigned DataCount      = 2,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [DbgAddressBits-1:0] addr_i,
  input  logic [3:0]                be_i,
  output logic                      rvalid_o,
  output logic                      err_o,
  input  logic                      cmd_valid_i,
  input  logic                      resumereq_i,
  output logic                      cmdbusy_o,
  output logic                      cmderror_valid_o,
  output logic [63:0]               flags_o,
  output logic                      wr_halted_en_o,
  output logic                      wr_going_en_o,
  output logic                      wr_resuming_en_o,
  output logic                      wr_exception_en_o,
  output logic                      wr_data_en_o,
  output logic [DbgAddressBits-1:0] wr_data_addr_o,
  output logic                      rd_where_en_o,
  output logic                      rd_data_en_o,
  output logic                      rd_prog_en_o,
  output logic                      rd_abs_cmd_en_o,
  output logic                      rd_flags_en_o,
  output logic [DbgAddressBits-1:0] rd_addr_o,
  input  logic                      halted_i
);

  dm_region_e region;
  logic       region_ro;

  dm_mem_addr_decode #(
    .DbgAddressBits(DbgAddressBits),
    .DataCount     (DataCount)
  ) u_decode (
    .addr_i     (addr_i),
    .region_o   (region),
    .read_only_o(region_ro)
  );

  // Byte enables go to the datapath directly; the controller itself never looks at them.
  logic unused_be;
  assign unused_be = ^be_i;

  logic wr_ok, rd_ok, any_en;
  assign wr_ok = req_i & we_i & ~region_ro;
  assign rd_ok = req_i & ~we_i;

  assign wr_halted_en_o    = wr_ok & (region == HALTED);
  assign wr_going_en_o     = wr_ok & (region == GOING);
  assign wr_resuming_en_o  = wr_ok & (region == RESUMING);
  assign wr_exception_en_o = wr_ok & (region == EXCEPTION);
  assign wr_data_en_o      = wr_ok & (region == DATA);
  // Mailbox regions have no read port, so reading them falls through to the error response.
  assign rd_where_en_o     = rd_ok & (region == WHERETO);
  assign rd_data_en_o      = rd_ok & (region == DATA);
  assign rd_prog_en_o      = rd_ok & (region == PROGBUF);
  assign rd_abs_cmd_en_o   = rd_ok & (region == ABSCMD);
  assign rd_flags_en_o     = rd_ok & (region == FLAGS);

  assign any_en = |{wr_halted_en_o, wr_going_en_o, wr_resuming_en_o, wr_exception_en_o,
                    wr_data_en_o, rd_where_en_o, rd_data_en_o, rd_prog_en_o,
                    rd_abs_cmd_en_o, rd_flags_en_o};

  assign rd_addr_o      = addr_i;
  assign wr_data_addr_o = addr_i;

  dm_cmd_state_e state_q;
  logic go_q, resume_q, busy_q, cmderror_q, rvalid_q, err_q;
  logic timeout;

`ifdef DM_CMD_TIMEOUT_EN
  logic [31:0] cnt_q;
  assign timeout = busy_q && (cnt_q == 32'(TimeoutCycles - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles == 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      go_q       <= 1'b0;
      resume_q   <= 1'b0;
      busy_q     <= 1'b0;
      cmderror_q <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
`ifdef DM_CMD_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      rvalid_q   <= req_i;
      err_q      <= req_i & ~any_en;
      cmderror_q <= 1'b0;
`ifdef DM_CMD_TIMEOUT_EN
      cnt_q      <= busy_q ? cnt_q + 32'd1 : '0;
`endif
      case (state_q)
        IDLE: begin
          if (cmd_valid_i && halted_i) begin
            state_q <= GO;
            go_q    <= 1'b1;
            busy_q  <= 1'b1;
          end else if (resumereq_i && halted_i) begin
            state_q  <= RESUME;
            resume_q <= 1'b1;
          end
        end
        GO: begin
          if (timeout) begin
            state_q    <= IDLE;
            go_q       <= 1'b0;
            busy_q     <= 1'b0;
            cmderror_q <= 1'b1;
          end else if (wr_going_en_o) begin
            state_q <= CMD_EXEC;
            go_q    <= 1'b0;
          end
        end
        CMD_EXEC: begin
          // A completing hart write wins over a timeout landing in the same cycle.
          if (wr_halted_en_o) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (wr_exception_en_o || timeout) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            cmderror_q <= 1'b1;
          end
        end
        RESUME: begin
          if (wr_resuming_en_o) begin
            state_q  <= IDLE;
            resume_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rvalid_o         = rvalid_q;
  assign err_o            = err_q;
  assign cmdbusy_o        = busy_q;
  assign cmderror_valid_o = cmderror_q;
  assign flags_o          = {{62{1'b0}}, resume_q, go_q};

endmodule

// File: tb/tb_dm_mem_ctrl.sv
// tb/tb_dm_mem_ctrl.sv - self-checking bench for dm_mem_ctrl
module tb_dm_mem_ctrl;
  localparam int AW = 12;
  localparam int DC = 2;
  localparam int TO = 16;
`ifdef DM_CMD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req, we, cmd_valid, resumereq, halted;
  logic [AW-1:0] addr;
  logic [3:0]    be;
  logic          rvalid, err, cmdbusy, cmderror;
  logic [63:0]   flags;
  logic          wr_halted_en, wr_going_en, wr_resuming_en, wr_exception_en, wr_data_en;
  logic          rd_where_en, rd_data_en, rd_prog_en, rd_abs_cmd_en, rd_flags_en;
  logic [AW-1:0] wr_data_addr, rd_addr;
  logic [9:0]    en_vec;

  always #5 clk = ~clk;

  dm_mem_ctrl #(.DbgAddressBits(AW), .DataCount(DC), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
    .rvalid_o(rvalid), .err_o(err), .cmd_valid_i(cmd_valid), .resumereq_i(resumereq),
    .cmdbusy_o(cmdbusy), .cmderror_valid_o(cmderror), .flags_o(flags),
    .wr_halted_en_o(wr_halted_en), .wr_going_en_o(wr_going_en),
    .wr_resuming_en_o(wr_resuming_en), .wr_exception_en_o(wr_exception_en),
    .wr_data_en_o(wr_data_en), .wr_data_addr_o(wr_data_addr),
    .rd_where_en_o(rd_where_en), .rd_data_en_o(rd_data_en), .rd_prog_en_o(rd_prog_en),
    .rd_abs_cmd_en_o(rd_abs_cmd_en), .rd_flags_en_o(rd_flags_en), .rd_addr_o(rd_addr),
    .halted_i(halted)
  );

  // Bit order: wr_halted, wr_going, wr_resuming, wr_exception, wr_data,
  //            rd_where, rd_data, rd_prog, rd_abs_cmd, rd_flags
  assign en_vec = {wr_halted_en, wr_going_en, wr_resuming_en, wr_exception_en, wr_data_en,
                   rd_where_en, rd_data_en, rd_prog_en, rd_abs_cmd_en, rd_flags_en};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: command progress tracked as "busy / hart has picked the command up".
  bit m_busy, m_ran, m_go, m_resume, m_cmderr, m_rvalid, m_err;
  int m_cnt;
  logic [9:0] last_en;

  task automatic model_reset();
    m_busy = 0; m_ran = 0; m_go = 0; m_resume = 0; m_cmderr = 0;
    m_rvalid = 0; m_err = 0; m_cnt = 0;
  endtask

  function automatic logic [9:0] model_en(input bit rq, input bit w, input int a);
    if (!rq) return 10'b0;
    if (w) begin
      if (a >= 'h100 && a < 'h104) return 10'b1000000000;
      if (a >= 'h108 && a < 'h10C) return 10'b0100000000;
      if (a >= 'h110 && a < 'h114) return 10'b0010000000;
      if (a >= 'h118 && a < 'h11C) return 10'b0001000000;
      if (a >= 'h380 && a < 'h380 + 4 * DC) return 10'b0000100000;
      return 10'b0;
    end
    if (a >= 'h300 && a < 'h304) return 10'b0000010000;
    if (a >= 'h380 && a < 'h380 + 4 * DC) return 10'b0000001000;
    if (a >= 'h340 && a < 'h380) return 10'b0000000100;
    if (a >= 'h330 && a < 'h340) return 10'b0000000010;
    if (a >= 'h400 && a < 'h408) return 10'b0000000001;
    return 10'b0;
  endfunction

  task automatic model_update(input bit rq, input bit cv, input bit rr, input bit h,
                              input logic [9:0] e);
    bit timed_out;
    m_rvalid = rq;
    m_err    = rq && (e == 10'b0);
    m_cmderr = 0;
    if (!m_busy && !m_resume) begin
      if (cv && h) begin
        m_busy = 1; m_go = 1; m_ran = 0; m_cnt = 0;
      end else if (rr && h) begin
        m_resume = 1;
      end
    end else if (m_resume) begin
      if (e[7]) m_resume = 0;
    end else begin
      timed_out = TO_EN && (m_cnt == TO - 1);
      if (!m_ran) begin
        if (timed_out) begin m_busy = 0; m_go = 0; m_cmderr = 1; end
        else if (e[8]) begin m_go = 0; m_ran = 1; end
      end else begin
        if (e[9]) m_busy = 0;
        else if (e[6] || timed_out) begin m_busy = 0; m_cmderr = 1; end
      end
      m_cnt++;
    end
  endtask

  // One bus cycle: drive at negedge, check decode, clock, check registered outputs.
  task automatic step(input bit rq, input bit w, input logic [AW-1:0] a,
                      input bit cv, input bit rr, input bit h);
    logic [9:0] e;
    req = rq; we = w; addr = a; be = 4'($urandom); cmd_valid = cv; resumereq = rr; halted = h;
    #1;
    e = model_en(rq, w, int'(a));
    last_en = en_vec;
    chk("enables", en_vec, e);
    chk("rd_addr", rd_addr, a);
    chk("wr_data_addr", wr_data_addr, a);
    @(posedge clk);
    model_update(rq, cv, rr, h, e);
    #1;
    chk("rvalid", rvalid, m_rvalid);
    chk("err", err, m_err);
    chk("flags", flags, {62'b0, m_resume, m_go});
    chk("cmdbusy", cmdbusy, m_busy);
    chk("cmderror", cmderror, m_cmderr);
    @(negedge clk);
  endtask

  task automatic idle(input bit h);
    step(0, 0, '0, 0, 0, h);
  endtask

  task automatic do_reset();
    req = 0; we = 0; cmd_valid = 0; resumereq = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_flags", flags, 64'h0);
    chk("rst_busy", cmdbusy, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cmderror", cmderror, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [9:0]    en;
    logic          err;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{1'b0, 12'h300, 10'b0000010000, 1'b0};
    vecs[1]  = '{1'b0, 12'h330, 10'b0000000010, 1'b0};
    vecs[2]  = '{1'b0, 12'h33F, 10'b0000000010, 1'b0};
    vecs[3]  = '{1'b0, 12'h340, 10'b0000000100, 1'b0};
    vecs[4]  = '{1'b0, 12'h37F, 10'b0000000100, 1'b0};
    vecs[5]  = '{1'b0, 12'h380, 10'b0000001000, 1'b0};
    vecs[6]  = '{1'b0, 12'h387, 10'b0000001000, 1'b0};
    vecs[7]  = '{1'b0, 12'h388, 10'b0000000000, 1'b1};
    vecs[8]  = '{1'b0, 12'h400, 10'b0000000001, 1'b0};
    vecs[9]  = '{1'b0, 12'h407, 10'b0000000001, 1'b0};
    vecs[10] = '{1'b0, 12'h408, 10'b0000000000, 1'b1};
    vecs[11] = '{1'b0, 12'h7F0, 10'b0000000000, 1'b1};
    vecs[12] = '{1'b0, 12'h100, 10'b0000000000, 1'b1};
    vecs[13] = '{1'b1, 12'h384, 10'b0000100000, 1'b0};
    vecs[14] = '{1'b1, 12'h340, 10'b0000000000, 1'b1};
    vecs[15] = '{1'b1, 12'h300, 10'b0000000000, 1'b1};
    vecs[16] = '{1'b1, 12'h32C, 10'b0000000000, 1'b1};

    req = 0; we = 0; addr = '0; be = '0; cmd_valid = 0; resumereq = 0; halted = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rvalid", rvalid, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_flags", flags, 64'h0);
    chk("reset_busy", cmdbusy, 1'b0);
    chk("reset_cmderror", cmderror, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Decode table
    for (int i = 0; i < $size(vecs); i++) begin
      step(1, vecs[i].we, vecs[i].addr, 0, 0, 0);
      chk($sformatf("tbl%0d_en", i), last_en, vecs[i].en);
      chk($sformatf("tbl%0d_err", i), err, vecs[i].err);
      chk($sformatf("tbl%0d_rvalid", i), rvalid, 1'b1);
    end
    idle(0);
    chk("rvalid_drops", rvalid, 1'b0);

    // Command not halted is dropped
    step(0, 0, '0, 1, 0, 0);
    chk("cmd_not_halted", cmdbusy, 1'b0);

    // Command go -> going -> halted
    step(0, 0, '0, 1, 0, 1);
    chk("go_flags", flags, 64'h1);
    chk("go_busy", cmdbusy, 1'b1);
    step(0, 0, '0, 0, 1, 1);
    chk("resume_dropped_busy", flags, 64'h1);
    step(1, 1, 12'h108, 0, 0, 1);
    chk("exec_flags", flags, 64'h0);
    chk("exec_busy", cmdbusy, 1'b1);
    step(1, 1, 12'h100, 0, 0, 1);
    chk("done_flags", flags, 64'h0);
    chk("done_busy", cmdbusy, 1'b0);

    // Exception during command
    step(0, 0, '0, 1, 0, 1);
    step(1, 1, 12'h108, 0, 0, 1);
    step(1, 1, 12'h118, 0, 0, 1);
    chk("exc_en", last_en, 10'b0001000000);
    chk("exc_pulse", cmderror, 1'b1);
    chk("exc_idle", cmdbusy, 1'b0);
    idle(1);
    chk("exc_pulse_end", cmderror, 1'b0);

    // cmd_valid beats resumereq
    step(0, 0, '0, 1, 1, 1);
    chk("prio_flags", flags, 64'h1);
    step(1, 1, 12'h108, 0, 0, 1);
    step(1, 1, 12'h100, 0, 0, 1);
    chk("prio_done", flags, 64'h0);
    step(0, 0, '0, 0, 1, 1);
    chk("resume_flags", flags, 64'h2);
    chk("resume_not_busy", cmdbusy, 1'b0);
    step(1, 1, 12'h110, 0, 0, 1);
    chk("resume_done", flags, 64'h0);

    // Timeout behaviour
    step(0, 0, '0, 1, 0, 1);
    for (int i = 1; i < TO; i++) idle(1);
    chk("to_busy_before", cmdbusy, 1'b1);
    idle(1);
`ifdef DM_CMD_TIMEOUT_EN
    chk("to_busy_after", cmdbusy, 1'b0);
    chk("to_flags_after", flags, 64'h0);
    chk("to_pulse", cmderror, 1'b1);
    // Completing write on the exact timeout cycle wins
    step(0, 0, '0, 1, 0, 1);
    step(1, 1, 12'h108, 0, 0, 1);
    for (int i = 2; i < TO; i++) idle(1);
    step(1, 1, 12'h100, 0, 0, 1);
    chk("to_race_busy", cmdbusy, 1'b0);
    chk("to_race_noerr", cmderror, 1'b0);
`else
    for (int i = 0; i < 2 * TO; i++) idle(1);
    chk("no_to_busy", cmdbusy, 1'b1);
    chk("no_to_flags", flags, 64'h1);
    step(1, 1, 12'h108, 0, 0, 1);
    step(1, 1, 12'h100, 0, 0, 1);
    chk("no_to_done", cmdbusy, 1'b0);
`endif

    // Reset in GO and in CMD_EXEC
    step(0, 0, '0, 1, 0, 1);
    do_reset();
    step(0, 0, '0, 1, 0, 1);
    step(1, 1, 12'h108, 0, 0, 1);
    do_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      logic [AW-1:0] a;
      case ($urandom_range(0, 7))
        0, 1, 2, 3: a = AW'(12'h100 + 8 * $urandom_range(0, 3));
        4:          a = AW'($urandom);
        5:          a = AW'(12'h380 + 4 * $urandom_range(0, DC));
        6:          a = AW'(12'h300 + $urandom_range(0, 'h7F));
        default:    a = AW'(12'h400 + $urandom_range(0, 15));
      endcase
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, a,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
